dm_mem_responder: RTL and testbench
===================================

Name: dm_mem_responder

Overview:
- MEM-stage data-memory responder: receives the EX/MEM-stage memory request (ALU address, store data, DMWr/DMRe controls) and serves it from a word-organised RAM with byte lanes.
- Performs sign/zero extension on loads.
- Inserts a configurable number of wait states and raises DMStall to freeze the upstream pipeline registers until the access completes.
- DataOut feeds the MEM/WB register DataOutIn input.

Parameters:
ADDR_W, 8, word-index width; RAM holds 2^ADDR_W 32-bit words.
WAIT_CYCLES, 1, extra wait cycles per access (0..15); 4-bit counter.

Ports:
clk  in  1  clock; all state changes on posedge.
rstn  in  1  reset.
Addr  in  32  byte address (ALU result); Addr[ADDR_W+1:2] selects the word; upper bits are ignored and wrap.
WriteData  in  32  store data (rt value).
DMWr  in  2  00 none, 01 sw, 10 sh, 11 sb.
DMRe  in  3  000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 treated as none.
DataOut  out  32  load result, registered.
DMStall  out  1  freeze IF/ID, ID/EX and EX/MEM while high.
AlignErr  out  1  one-cycle pulse: the completed access was misaligned.

Reset (already decided): one clock, clk; reset rstn is asynchronous and active-low.

Behaviour:
- Request present: DMWr != 00 or a valid DMRe.
- If DMWr != 00 and DMRe is also valid, the write wins and the read is ignored (DataOut = 0).
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request:
  - DMStall = 0; remain in IDLE.
- IDLE, request present:
  - DMStall = 1 combinationally in the same cycle.
  - Latch Addr, WriteData, DMWr and DMRe into internal registers.
  - Load cnt = WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else go to DONE.
- WAIT:
  - DMStall = 1.
  - cnt decrements each cycle.
  - When cnt == 1, perform the access on that edge and go to DONE.
  - Inputs are ignored in WAIT; the latched copy is authoritative.
- Access edge (entering DONE):
  - Write: byte lanes are enabled per Addr[1:0].
    - sw writes all 4 lanes.
    - sh writes lanes {1,0} or {3,2} per Addr[1]; data from WriteData[15:0].
    - sb writes the lane selected by Addr[1:0]; data from WriteData[7:0].
  - Read: DataOut <= extended result.
    - lw: full word.
    - lh/lhu: halfword per Addr[1], sign/zero-extended.
    - lb/lbu: byte per Addr[1:0], sign/zero-extended.
  - Misaligned access (lw/sw with Addr[1:0] != 0, or lh/lhu/sh with Addr[0] = 1):
    - No RAM write.
    - DataOut <= 0.
    - AlignErr <= 1.
- DONE:
  - DMStall = 0, so the pipeline advances this cycle.
  - DataOut holds the result.
  - AlignErr is high only in this cycle.
  - Next state is always IDLE; a new request is accepted in the following cycle (back-to-back accesses cost WAIT_CYCLES + 1 stall cycles each).
- DataOut persists until the next access edge. A write access sets DataOut <= 0.
- Reset values:
  - state IDLE, cnt 0, DataOut 0, DMStall 0, AlignErr 0, latched request cleared.
  - RAM contents are not reset.
- Reset mid-access (WAIT): the access is aborted, no RAM write occurs, and the FSM returns to IDLE.
- Stall-cycle count per access is exactly WAIT_CYCLES + 1.

Test Plan:
- WAIT_CYCLES=1: sw Addr=0x10, WriteData=0xDEADBEEF; then lw Addr=0x10.
  -> DMStall high 2 cycles per access; DataOut=0xDEADBEEF in DONE.
- Over word 0x10=0xDEADBEEF: sb Addr=0x11 WriteData=0x55, then lb 0x11, lbu 0x13, lh 0x12.
  -> lb=0x00000055, lbu=0x000000DE, lh=0xFFFFDEAD.
- sw Addr=0x22 WriteData=0x12345678.
  -> AlignErr pulses 1 cycle; a following lw 0x20 returns the prior contents unchanged.
- lhu Addr=0x03.
  -> AlignErr=1, DataOut=0.
- DMWr=01 and DMRe=001 simultaneously, Addr=0x30, WriteData=0xA5A5A5A5.
  -> word written; DataOut=0.
- WAIT_CYCLES=3: assert rstn=0 during WAIT of sw Addr=0x40 WriteData=0xFFFFFFFF, then lw 0x40.
  -> word unchanged; DMStall=0 immediately on reset; lw stalls exactly 4 cycles.

Source files
------------

// File: rtl/dm_mem_responder_if.sv
// Memory request/response bundle between the EX/MEM stage and the
// data-memory responder.
interface dm_mem_responder_if;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [1:0]  DMWr;
   logic [2:0]  DMRe;
   logic [31:0] DataOut;
   logic        DMStall;
   logic        AlignErr;

   modport master (
      output Addr, WriteData, DMWr, DMRe,
      input  DataOut, DMStall, AlignErr
   );

   modport slave (
      input  Addr, WriteData, DMWr, DMRe,
      output DataOut, DMStall, AlignErr
   );
endinterface

// File: rtl/dm_mem_responder.sv
// MEM-stage data-memory responder: word-organised RAM with byte lanes,
// load sign/zero extension, configurable wait states and a pipeline stall.
module dm_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rstn,
   dm_mem_responder_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addrQ;
   logic [31:0] wdataQ;
   logic [1:0]  wrQ;
   logic [2:0]  reQ;
   logic [31:0] dataOut;
   logic        alignErr;

   logic [31:0] mem [DEPTH];

   logic              reqPresent;
   logic              accFire;
   logic [31:0]       accAddr;
   logic [31:0]       accData;
   logic [1:0]        accWr;
   logic [2:0]        accRe;
   logic              isWrite;
   logic              isRead;
   logic              misaligned;
   logic [ADDR_W-1:0] wordIdx;
   logic [31:0]       rdWord;
   logic [15:0]       rdHalf;
   logic [7:0]        rdByte;
   logic [31:0]       loadVal;
   logic [3:0]        byteEn;
   logic [31:0]       wrWord;
   logic              memWe;
   logic              unusedBits;

   // Request decode and access-source selection
   always_comb begin
      reqPresent = (bus.DMWr != 2'b00) || (bus.DMRe inside {[3'd1:3'd5]});
      // With no wait states the access happens on the accepting edge, so
      // the live inputs are used; otherwise the latched copy is used.
      accAddr = (state == IDLE) ? bus.Addr      : addrQ;
      accData = (state == IDLE) ? bus.WriteData : wdataQ;
      accWr   = (state == IDLE) ? bus.DMWr      : wrQ;
      accRe   = (state == IDLE) ? bus.DMRe      : reQ;
      accFire = ((state == IDLE) && reqPresent && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (cnt == 4'd1));
      isWrite = (accWr != 2'b00);
      isRead  = !isWrite && (accRe inside {[3'd1:3'd5]});
   end

   // Alignment check: a write wins over a simultaneous read
   always_comb begin
      misaligned = 1'b0;
      if (isWrite) begin
         misaligned = ((accWr == 2'b01) && (accAddr[1:0] != 2'b00)) ||
                      ((accWr == 2'b10) && accAddr[0]);
      end else if (isRead) begin
         misaligned = ((accRe == 3'd1) && (accAddr[1:0] != 2'b00)) ||
                      (((accRe == 3'd2) || (accRe == 3'd3)) && accAddr[0]);
      end
   end

   // Load path: lane selection and extension
   always_comb begin
      wordIdx = accAddr[ADDR_W+1:2];
      rdWord  = mem[wordIdx];
      rdHalf  = accAddr[1] ? rdWord[31:16] : rdWord[15:0];
      case (accAddr[1:0])
         2'd0:    rdByte = rdWord[7:0];
         2'd1:    rdByte = rdWord[15:8];
         2'd2:    rdByte = rdWord[23:16];
         default: rdByte = rdWord[31:24];
      endcase
      case (accRe)
         3'd1:    loadVal = rdWord;
         3'd2:    loadVal = {{16{rdHalf[15]}}, rdHalf};
         3'd3:    loadVal = {16'h0000, rdHalf};
         3'd4:    loadVal = {{24{rdByte[7]}}, rdByte};
         3'd5:    loadVal = {24'h000000, rdByte};
         default: loadVal = '0;
      endcase
   end

   // Store path: byte-lane enables and replicated write data
   always_comb begin
      byteEn = '0;
      wrWord = accData;
      case (accWr)
         2'b01: byteEn = 4'b1111;
         2'b10: begin
            byteEn = accAddr[1] ? 4'b1100 : 4'b0011;
            wrWord = {2{accData[15:0]}};
         end
         2'b11: begin
            byteEn = 4'b0001 << accAddr[1:0];
            wrWord = {4{accData[7:0]}};
         end
         default: byteEn = '0;
      endcase
      memWe      = accFire && isWrite && !misaligned && rstn;
      unusedBits = &{1'b0, accAddr[31:ADDR_W+2]};
   end

   // RAM write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
         end
      end
   end

   // Access FSM with registered load result and alignment pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         addrQ    <= '0;
         wdataQ   <= '0;
         wrQ      <= '0;
         reQ      <= '0;
         dataOut  <= '0;
         alignErr <= 1'b0;
      end else begin
         alignErr <= 1'b0;
         if (accFire) begin
            alignErr <= misaligned;
            dataOut  <= (isRead && !misaligned) ? loadVal : '0;
         end
         case (state)
            IDLE: begin
               if (reqPresent) begin
                  addrQ  <= bus.Addr;
                  wdataQ <= bus.WriteData;
                  wrQ    <= bus.DMWr;
                  reQ    <= bus.DMRe;
                  cnt    <= 4'(WAIT_CYCLES);
                  state  <= (WAIT_CYCLES > 0) ? WAIT : DONE;
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stall rises combinationally on acceptance so the request is frozen
   assign bus.DMStall  = (state == WAIT) || ((state == IDLE) && reqPresent);
   assign bus.DataOut  = dataOut;
   assign bus.AlignErr = alignErr;

endmodule

// File: tb/tb_dm_mem_responder.sv
// Directed bench for dm_mem_responder: one instance with one wait state,
// one with three wait states for the reset-abort scenario.
module tb_dm_mem_responder;

   logic clk = 1'b0;
   logic rstn1;
   logic rstn2;
   int   nCmp = 0;
   int   nErr = 0;

   logic [31:0] gotData;
   logic        gotAlign;
   int          gotStalls;

   dm_mem_responder_if b1 ();
   dm_mem_responder_if b2 ();

   dm_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u1 (
      .clk  (clk),
      .rstn (rstn1),
      .bus  (b1.slave)
   );

   dm_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u2 (
      .clk  (clk),
      .rstn (rstn2),
      .bus  (b2.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit which, input logic [1:0] wr, input logic [2:0] re,
                        input logic [31:0] a, input logic [31:0] d);
      if (which) begin
         b2.DMWr = wr; b2.DMRe = re; b2.Addr = a; b2.WriteData = d;
      end else begin
         b1.DMWr = wr; b1.DMRe = re; b1.Addr = a; b1.WriteData = d;
      end
   endtask

   function automatic logic stallOf(input bit which);
      return which ? b2.DMStall : b1.DMStall;
   endfunction

   // Issue one request and count stall cycles until DONE (bounded)
   task automatic access(input bit which, input logic [1:0] wr, input logic [2:0] re,
                         input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      drive(which, wr, re, a, d);
      gotStalls = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!stallOf(which)) break;
         gotStalls++;
         @(posedge clk);
         #1;
         drive(which, 2'b00, 3'b000, 32'h0, 32'h0);
         @(negedge clk);
      end
      gotData  = which ? b2.DataOut  : b1.DataOut;
      gotAlign = which ? b2.AlignErr : b1.AlignErr;
      drive(which, 2'b00, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn1 = 1'b0;
      rstn2 = 1'b0;
      drive(0, 2'b00, 3'b000, 32'h0, 32'h0);
      drive(1, 2'b00, 3'b000, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("rst DataOut",  b1.DataOut,  32'h0);
      check("rst DMStall",  {31'b0, b1.DMStall},  32'h0);
      check("rst AlignErr", {31'b0, b1.AlignErr}, 32'h0);
      check("rst2 DataOut", b2.DataOut,  32'h0);
      rstn1 = 1'b1;
      rstn2 = 1'b1;

      access(0, 2'b01, 3'b000, 32'h10, 32'hDEADBEEF);
      check("sw10 stalls", 32'(gotStalls), 32'd2);
      check("sw10 data",   gotData, 32'h0);
      check("sw10 align",  {31'b0, gotAlign}, 32'h0);

      access(0, 2'b00, 3'b001, 32'h10, 32'h0);
      check("lw10 stalls", 32'(gotStalls), 32'd2);
      check("lw10 data",   gotData, 32'hDEADBEEF);

      access(0, 2'b11, 3'b000, 32'h11, 32'h00000055);
      check("sb11 data", gotData, 32'h0);
      access(0, 2'b00, 3'b100, 32'h11, 32'h0);
      check("lb11",  gotData, 32'h00000055);
      access(0, 2'b00, 3'b101, 32'h13, 32'h0);
      check("lbu13", gotData, 32'h000000DE);
      access(0, 2'b00, 3'b010, 32'h12, 32'h0);
      check("lh12",  gotData, 32'hFFFFDEAD);
      access(0, 2'b00, 3'b100, 32'h10, 32'h0);
      check("lb10",  gotData, 32'hFFFFFFEF);
      access(0, 2'b00, 3'b011, 32'h12, 32'h0);
      check("lhu12", gotData, 32'h0000DEAD);

      access(0, 2'b01, 3'b000, 32'h20, 32'hCAFEF00D);
      access(0, 2'b01, 3'b000, 32'h22, 32'h12345678);
      check("sw22 stalls", 32'(gotStalls), 32'd2);
      check("sw22 align",  {31'b0, gotAlign}, 32'h1);
      check("sw22 data",   gotData, 32'h0);
      @(negedge clk);
      #1;
      check("sw22 align pulse end", {31'b0, b1.AlignErr}, 32'h0);
      access(0, 2'b00, 3'b001, 32'h20, 32'h0);
      check("lw20 data",  gotData, 32'hCAFEF00D);
      check("lw20 align", {31'b0, gotAlign}, 32'h0);

      access(0, 2'b00, 3'b011, 32'h03, 32'h0);
      check("lhu03 align", {31'b0, gotAlign}, 32'h1);
      check("lhu03 data",  gotData, 32'h0);

      access(0, 2'b00, 3'b001, 32'h10, 32'h0);
      check("lw10 after sb", gotData, 32'hDEAD55EF);

      access(0, 2'b01, 3'b001, 32'h30, 32'hA5A5A5A5);
      check("wr+rd data",  gotData, 32'h0);
      check("wr+rd align", {31'b0, gotAlign}, 32'h0);
      access(0, 2'b00, 3'b001, 32'h30, 32'h0);
      check("lw30 data", gotData, 32'hA5A5A5A5);

      access(0, 2'b10, 3'b000, 32'h12, 32'hFFFF1234);
      access(0, 2'b00, 3'b001, 32'h10, 32'h0);
      check("sh12 then lw10", gotData, 32'h123455EF);

      access(0, 2'b00, 3'b001, 32'hFFFFFC10, 32'h0);
      check("lw wrap", gotData, 32'h123455EF);

      @(negedge clk);
      drive(0, 2'b00, 3'b110, 32'h10, 32'h0);
      #1;
      check("re110 no stall", {31'b0, b1.DMStall}, 32'h0);
      @(posedge clk);
      #1;
      check("re110 still idle", {31'b0, b1.DMStall}, 32'h0);
      check("re110 data held",  b1.DataOut, 32'h123455EF);
      drive(0, 2'b00, 3'b000, 32'h0, 32'h0);

      access(0, 2'b00, 3'b010, 32'h11, 32'h0);
      check("lh11 align", {31'b0, gotAlign}, 32'h1);
      check("lh11 data",  gotData, 32'h0);

      access(1, 2'b01, 3'b000, 32'h40, 32'h01234567);
      check("u2 sw40 stalls", 32'(gotStalls), 32'd4);

      @(negedge clk);
      drive(1, 2'b01, 3'b000, 32'h40, 32'hFFFFFFFF);
      #1;
      check("u2 accept stall", {31'b0, b2.DMStall}, 32'h1);
      @(posedge clk);
      #1;
      drive(1, 2'b00, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check("u2 wait stall", {31'b0, b2.DMStall}, 32'h1);
      @(posedge clk);
      #1;
      rstn2 = 1'b0;
      #1;
      check("u2 reset drops stall", {31'b0, b2.DMStall}, 32'h0);
      repeat (2) @(negedge clk);
      rstn2 = 1'b1;

      access(1, 2'b00, 3'b001, 32'h40, 32'h0);
      check("u2 lw40 stalls", 32'(gotStalls), 32'd4);
      check("u2 lw40 data",   gotData, 32'h01234567);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
